// File: rtl/serial_cmd_pkg.sv
// serial_cmd_pkg
// Shared definitions for the serial command controller:
//   - state_t            controller state encoding
//   - CMD_* constants    command codes carried in the header frame
//   - DEF_* values       default parameter values for the controller
//   - PAR_W              width of the trailing parity bit (0 or 1)
// Optional feature macro: SERIAL_CMD_CTRL_PARITY_EN adds an even-parity
// bit after the command field of every header frame.
package serial_cmd_pkg;

    typedef enum logic [2:0] {
        HUNT  = 3'd0,
        LOAD  = 3'd1,
        SHOUT = 3'd2,
        SHIN  = 3'd3,
        UPD   = 3'd4,
        CLR   = 3'd5
    } state_t;

    localparam int CMD_NOP        = 0;
    localparam int CMD_LOAD_SHOUT = 1;
    localparam int CMD_SHIN       = 2;
    localparam int CMD_CLR        = 3;

    localparam int         DEF_HDR_W   = 3;
    localparam logic [2:0] DEF_HDR_PAT = 3'b101;
    localparam int         DEF_CMD_W   = 2;
    localparam int         DEF_DATA_W  = 8;

`ifdef SERIAL_CMD_CTRL_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif

endpackage

// File: rtl/serial_hdr_detect.sv
// serial_hdr_detect
// Header window and match logic. While hunt is high the serial stream is
// shifted MSB-first into a window of HDR_W+CMD_W(+1 parity) bits. A match
// is flagged when the upper HDR_W bits equal HDR_PAT. The window is
// cleared on the edge that follows a match (the controller acts on it on
// that edge), so no bit is ever part of two frames, and it is held at
// zero whenever the controller is not hunting.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   hunt         controller is in its hunting state
//   data_in      serial stream
//   match        header present in the window
//   cmd          command field of the window
//   parity_ok    trailing parity bit agrees (always 1 without parity)
// Optional feature macro: SERIAL_CMD_CTRL_PARITY_EN.
module serial_hdr_detect
    import serial_cmd_pkg::*;
#(
    parameter int               HDR_W   = DEF_HDR_W,
    parameter logic [HDR_W-1:0] HDR_PAT = HDR_W'(DEF_HDR_PAT),
    parameter int               CMD_W   = DEF_CMD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hunt,
    input  logic             data_in,
    output logic             match,
    output logic [CMD_W-1:0] cmd,
    output logic             parity_ok
);

    localparam int WIN_W = HDR_W + CMD_W + PAR_W;

    logic [WIN_W-1:0] window_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            window_reg <= '0;
        end else if (!hunt || match) begin
            window_reg <= '0;
        end else begin
            window_reg <= {window_reg[WIN_W-2:0], data_in};
        end
    end

    assign match = (window_reg[WIN_W-1 -: HDR_W] == HDR_PAT);
    assign cmd   = window_reg[PAR_W +: CMD_W];

`ifdef SERIAL_CMD_CTRL_PARITY_EN
    // Even parity: the trailing bit equals the XOR of the command bits.
    assign parity_ok = ((^cmd) == window_reg[0]);
`else
    assign parity_ok = 1'b1;
`endif

endmodule

// File: rtl/serial_cmd_ctrl.sv
// serial_cmd_ctrl
// Serial command controller. Hunts for a header+command frame on data_in,
// then drives an external shift register through one of:
//   LOAD  (1 cycle parallel load) -> SHOUT (DATA_W cycles shifting out)
//   SHIN  (DATA_W cycles shifting in) -> UPD (1 cycle latch strobe)
//   CLR   (1 cycle clear strobe)
// All strobes are decoded from the state register only.
// Ports:
//   clk                    clock
//   reset                  asynchronous active-high reset
//   data_in                serial header/command stream, MSB first
//   data_out_shift_reg_in  serial bit from the external shift register
//   serial_out             shifted-out data (SHOUT only, else 0)
//   write                  shift-out phase active
//   enable_shift_register  shift enable (SHOUT and SHIN)
//   write_shift_register   parallel-load strobe (LOAD)
//   reset_shift_reg_out    shift-register clear strobe (CLR)
//   update                 latch strobe (UPD)
//   busy                   high in every state except HUNT
//   cmd_err                one-cycle pulse on a rejected command
// Optional feature macro: SERIAL_CMD_CTRL_PARITY_EN (parity-checked
// frames; without it cmd_err is constant 0).
module serial_cmd_ctrl
    import serial_cmd_pkg::*;
#(
    parameter int               HDR_W   = DEF_HDR_W,
    parameter logic [HDR_W-1:0] HDR_PAT = HDR_W'(DEF_HDR_PAT),
    parameter int               CMD_W   = DEF_CMD_W,
    parameter int               DATA_W  = DEF_DATA_W
) (
    input  logic clk,
    input  logic reset,
    input  logic data_in,
    input  logic data_out_shift_reg_in,
    output logic serial_out,
    output logic write,
    output logic enable_shift_register,
    output logic write_shift_register,
    output logic reset_shift_reg_out,
    output logic update,
    output logic busy,
    output logic cmd_err
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             hunt;
    logic             match;
    logic [CMD_W-1:0] cmd;
    logic             parity_ok;
    logic             cnt_last;

    assign hunt     = (state_reg == HUNT);
    assign cnt_last = (cnt_reg == CNT_W'(DATA_W - 1));

    serial_hdr_detect #(
        .HDR_W   (HDR_W),
        .HDR_PAT (HDR_PAT),
        .CMD_W   (CMD_W)
    ) u_hdr_detect (
        .clk       (clk),
        .reset     (reset),
        .hunt      (hunt),
        .data_in   (data_in),
        .match     (match),
        .cmd       (cmd),
        .parity_ok (parity_ok)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= HUNT;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // The counter only advances while staying in a shift state, so it is
    // zero on entry to every state and stops at DATA_W-1.
    always_comb begin
        state_next = state_reg;
        cnt_next   = '0;
        case (state_reg)
            HUNT: begin
                if (match && parity_ok) begin
                    case (cmd)
                        CMD_W'(CMD_NOP):        state_next = HUNT;
                        CMD_W'(CMD_LOAD_SHOUT): state_next = LOAD;
                        CMD_W'(CMD_SHIN):       state_next = SHIN;
                        CMD_W'(CMD_CLR):        state_next = CLR;
                        default:                state_next = HUNT;
                    endcase
                end
            end
            LOAD: state_next = SHOUT;
            SHOUT: begin
                if (cnt_last) begin
                    state_next = HUNT;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            SHIN: begin
                if (cnt_last) begin
                    state_next = UPD;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            UPD:     state_next = HUNT;
            CLR:     state_next = HUNT;
            default: state_next = HUNT;
        endcase
    end

    always_comb begin
        serial_out            = 1'b0;
        write                 = 1'b0;
        enable_shift_register = 1'b0;
        write_shift_register  = 1'b0;
        reset_shift_reg_out   = 1'b0;
        update                = 1'b0;
        busy                  = (state_reg != HUNT);
        case (state_reg)
            LOAD: write_shift_register = 1'b1;
            SHOUT: begin
                write                 = 1'b1;
                enable_shift_register = 1'b1;
                serial_out            = data_out_shift_reg_in;
            end
            SHIN:    enable_shift_register = 1'b1;
            UPD:     update                = 1'b1;
            CLR:     reset_shift_reg_out   = 1'b1;
            default: ;
        endcase
    end

`ifdef SERIAL_CMD_CTRL_PARITY_EN
    // Registered so the error pulse lines up with the cycle in which an
    // accepted command would have entered its state.
    logic cmd_err_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_err_reg <= 1'b0;
        end else begin
            cmd_err_reg <= hunt && match && !parity_ok;
        end
    end

    assign cmd_err = cmd_err_reg;
`else
    assign cmd_err = 1'b0;
`endif

endmodule

// File: doc/serial_cmd_ctrl.md
SERIAL_CMD_CTRL -- requirements
Module: serial_cmd_ctrl

Interface
REQ-001 SHALL have parameter HDR_W, default 3, header marker length in bits.
REQ-002 SHALL have parameter HDR_PAT, default 3'b101, header marker value, MSB received first.
REQ-003 SHALL have parameter CMD_W, default 2, command field width (>=2).
REQ-004 SHALL have parameter DATA_W, default 8, data bits per transfer (>=1).
REQ-005 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port: data_in  in  1  serial header/command/data stream, MSB first.
REQ-008 SHALL have port: data_out_shift_reg_in  in  1  serial bit from external shift register.
REQ-009 SHALL have ports (all out, 1 bit):
- serial_out: shifted-out data
- write: shift-out phase active
- enable_shift_register: shift enable
- write_shift_register: parallel-load strobe
- reset_shift_reg_out: shift-register clear strobe
- update: latch strobe
- busy: not hunting
- cmd_err: command rejected

Function
REQ-010 SHALL implement states HUNT, LOAD, SHOUT, SHIN, UPD, CLR; HUNT is the reset state.
REQ-011 In HUNT, SHALL shift data_in into a window register of HDR_W+CMD_W bits (plus 1 when parity is enabled) every cycle.
REQ-012 SHALL detect a match when the window's upper HDR_W bits equal HDR_PAT; the window clears on the edge a match is acted on, so bits are never reused.
REQ-013 Command decode, with cmd = the lower CMD_W bits:
- 0: NOP, stay in HUNT
- 1: LOAD -> SHOUT
- 2: SHIN -> UPD
- 3: CLR
- values >3: NOP
REQ-014 Latency: with the last command bit sampled at edge N, the command state SHALL be entered at edge N+1.
REQ-015 LOAD SHALL last 1 cycle with write_shift_register=1.
REQ-016 SHOUT SHALL last exactly DATA_W cycles with write=1, enable_shift_register=1, serial_out=data_out_shift_reg_in; then HUNT.
REQ-017 SHIN SHALL last exactly DATA_W cycles with enable_shift_register=1; then UPD.
REQ-018 UPD and CLR SHALL each last 1 cycle, asserting update and reset_shift_reg_out respectively; then HUNT.
REQ-019 Outputs SHALL be Moore-decoded from the state; serial_out=0 outside SHOUT; busy=1 in every state except HUNT.
REQ-020 The data counter SHALL be $clog2(DATA_W+1) bits wide, load 0 on state entry, and terminate at DATA_W-1 without wrapping.
REQ-021 data_in SHALL be ignored for header detection outside HUNT; the window holds zeros there.
REQ-022 A header match arriving on the same edge that a transfer ends SHALL NOT be honoured.

Reset
REQ-023 reset=1 SHALL asynchronously force HUNT, clear window and counter, and drive all outputs to 0.
REQ-024 Reset asserted mid-transfer SHALL abort the transfer with no further strobes; the FSM SHALL resume in HUNT on the first edge after deassertion.

Configuration
REQ-025 With SERIAL_CMD_CTRL_PARITY_EN defined, the window SHALL carry one extra trailing bit, the even parity of the cmd bits.
REQ-026 On a parity mismatch, cmd_err SHALL pulse for 1 cycle, the command SHALL be discarded, and the FSM SHALL stay in HUNT.
REQ-027 Without SERIAL_CMD_CTRL_PARITY_EN, there SHALL be no parity bit, cmd_err SHALL be tied to 0, and latency is per REQ-014.

Structure
REQ-028 Package serial_cmd_pkg SHALL hold:
- the state enum
- command code constants (NOP/LOAD_SHOUT/SHIN/CLR)
- default parameter values
REQ-029 Header window and match logic SHALL be the sub-module serial_hdr_detect.

Verification
REQ-030 Stream 1,0,1,0,1 (default parameters) -> write_shift_register high 1 cycle, then write=1 for 8 cycles with serial_out following data_out_shift_reg_in.
REQ-031 Stream 1,0,1,1,0, then 8 data bits -> enable_shift_register high 8 cycles, then update high 1 cycle, busy low after.
REQ-032 Stream 1,0,1,1,1 -> reset_shift_reg_out high 1 cycle; stream 1,0,1,0,0 -> no strobe, busy stays 0.
REQ-033 Reset asserted at SHOUT count 4 -> all outputs 0 in the same cycle; a new 1,0,1,0,1 after release is accepted.
REQ-034 Stream 1,1,1,0,1 (bad header) -> no strobes; DATA_W=16, CMD_W=3, stream 1,0,1,0,0,1 -> 16-cycle SHOUT.
REQ-035 With PARITY_EN, stream 1,0,1,0,1,0 (bad parity) -> cmd_err 1-cycle pulse and no strobe; stream 1,0,1,0,1,1 -> normal LOAD.
